vga_output_stage: RTL and testbench

Final video stage, directly downstream of the object multiplexer. Generates the 640x480@60 raster (horizontal/vertical counters, sync and blanking) and publishes the current pixel coordinate to the drawing logic. Captures the multiplexer's registered RGB, forces it to black outside the active area, and delays sync/blank so they line up with the pipelined colour at the DAC pins.

---
 rtl/vga_output_stage.sv | 135 +++++++++++++
 tb/tb_vga_output_stage.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/vga_output_stage.sv
// 640x480@60 raster generator and output register stage: counters, sync/blank
// generation, control delay to match the colour pipeline, and blanked RGB to the DAC.
module vga_output_stage #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int PIPE_DELAY = 1
) (
  input  logic        CLK,
  input  logic        RESETn,
  input  logic [7:0]  m_mVGA_R,
  input  logic [7:0]  m_mVGA_G,
  input  logic [7:0]  m_mVGA_B,
  output logic [10:0] pixelX,
  output logic [10:0] pixelY,
  output logic        startOfFrame,
  output logic [7:0]  VGA_R,
  output logic [7:0]  VGA_G,
  output logic [7:0]  VGA_B,
  output logic        VGA_HS,
  output logic        VGA_VS,
  output logic        VGA_BLANK_N,
  output logic        VGA_SYNC_N
);

  typedef struct packed {
    logic hs_n;
    logic vs_n;
    logic active;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '{hs_n: 1'b1, vs_n: 1'b1, active: 1'b0};

  localparam int          H_TOTAL      = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int          V_TOTAL      = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [10:0] H_LAST       = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST       = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_VIS        = 11'(H_ACTIVE);
  localparam logic [10:0] V_VIS        = 11'(V_ACTIVE);
  localparam logic [10:0] H_SYNC_START = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] H_SYNC_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] V_SYNC_START = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] V_SYNC_END   = 11'(V_ACTIVE + V_FP + V_SYNC);

  logic [10:0] h_cnt_q, h_cnt_d;
  logic [10:0] v_cnt_q, v_cnt_d;
  ctrl_t       ctrl_raw, ctrl_dly;
  ctrl_t       out_ctrl_q, out_ctrl_d;
  logic [23:0] rgb_q, rgb_d;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    h_cnt_d = h_cnt_q + 11'd1;
    v_cnt_d = v_cnt_q;
    if (h_cnt_q == H_LAST) begin
      h_cnt_d = '0;
      v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 11'd1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  always_comb begin
    ctrl_raw        = CTRL_IDLE;
    ctrl_raw.active = (h_cnt_q < H_VIS) && (v_cnt_q < V_VIS);
    ctrl_raw.hs_n   = !((h_cnt_q >= H_SYNC_START) && (h_cnt_q < H_SYNC_END));
    ctrl_raw.vs_n   = !((v_cnt_q >= V_SYNC_START) && (v_cnt_q < V_SYNC_END));
  end

  // Controls are delayed to arrive alongside the colour the multiplexer computes.
  if (PIPE_DELAY == 0) begin : g_no_delay
    assign ctrl_dly = ctrl_raw;
  end else begin : g_delay
    ctrl_t pipe_q [PIPE_DELAY];
    ctrl_t pipe_d [PIPE_DELAY];

    always_comb begin
      pipe_d[0] = ctrl_raw;
      for (int i = 1; i < PIPE_DELAY; i++) pipe_d[i] = pipe_q[i-1];
    end

    // NOTE: this shift register is reset (unlike a datapath memory) because it carries
    // sync/blank; stale stages would emit bogus sync pulses right after reset.
    always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
        for (int i = 0; i < PIPE_DELAY; i++) pipe_q[i] <= CTRL_IDLE;
      end else begin
        for (int i = 0; i < PIPE_DELAY; i++) pipe_q[i] <= pipe_d[i];
      end
    end

    assign ctrl_dly = pipe_q[PIPE_DELAY-1];
  end

  always_comb begin
    out_ctrl_d = ctrl_dly;
    rgb_d      = ctrl_dly.active ? {m_mVGA_R, m_mVGA_G, m_mVGA_B} : 24'h0;
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      out_ctrl_q <= CTRL_IDLE;
      rgb_q      <= '0;
    end else begin
      out_ctrl_q <= out_ctrl_d;
      rgb_q      <= rgb_d;
    end
  end

  assign pixelX       = h_cnt_q;
  assign pixelY       = v_cnt_q;
  assign startOfFrame = (h_cnt_q == 11'd0) && (v_cnt_q == 11'd0);
  assign VGA_R        = rgb_q[23:16];
  assign VGA_G        = rgb_q[15:8];
  assign VGA_B        = rgb_q[7:0];
  assign VGA_HS       = out_ctrl_q.hs_n;
  assign VGA_VS       = out_ctrl_q.vs_n;
  assign VGA_BLANK_N  = out_ctrl_q.active;
  assign VGA_SYNC_N   = 1'b0;

endmodule

// File: tb/tb_vga_output_stage.sv
// Bench for vga_output_stage: default timing, a PIPE_DELAY=3 copy, and a shrunken
// raster (16x12) so whole-frame behaviour fits in a short run.
module tb_vga_output_stage;

  logic       CLK;
  logic       RESETn;
  logic [7:0] m_r, m_g, m_b;

  logic [10:0] px, py, px3, py3, px_s, py_s;
  logic        sof, sof3, sof_s;
  logic [7:0]  vr, vg, vb, vr3, vg3, vb3, vr_s, vg_s, vb_s;
  logic        hs, vs, bl, sn, hs3, vs3, bl3, sn3, hs_s, vs_s, bl_s, sn_s;

  int n_checks = 0;
  int n_fail   = 0;

  vga_output_stage dut (
    .CLK(CLK), .RESETn(RESETn), .m_mVGA_R(m_r), .m_mVGA_G(m_g), .m_mVGA_B(m_b),
    .pixelX(px), .pixelY(py), .startOfFrame(sof), .VGA_R(vr), .VGA_G(vg), .VGA_B(vb),
    .VGA_HS(hs), .VGA_VS(vs), .VGA_BLANK_N(bl), .VGA_SYNC_N(sn));

  vga_output_stage #(.PIPE_DELAY(3)) dut3 (
    .CLK(CLK), .RESETn(RESETn), .m_mVGA_R(m_r), .m_mVGA_G(m_g), .m_mVGA_B(m_b),
    .pixelX(px3), .pixelY(py3), .startOfFrame(sof3), .VGA_R(vr3), .VGA_G(vg3), .VGA_B(vb3),
    .VGA_HS(hs3), .VGA_VS(vs3), .VGA_BLANK_N(bl3), .VGA_SYNC_N(sn3));

  // 16 clocks per line (sync at 10..12), 12 lines per frame (vsync on lines 8..9).
  vga_output_stage #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(2), .PIPE_DELAY(1)) dut_s (
    .CLK(CLK), .RESETn(RESETn), .m_mVGA_R(m_r), .m_mVGA_G(m_g), .m_mVGA_B(m_b),
    .pixelX(px_s), .pixelY(py_s), .startOfFrame(sof_s), .VGA_R(vr_s), .VGA_G(vg_s), .VGA_B(vb_s),
    .VGA_HS(hs_s), .VGA_VS(vs_s), .VGA_BLANK_N(bl_s), .VGA_SYNC_N(sn_s));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef enum int {S_BLANK, S_HS, S_PX, S_PY, S_BLANK3, S_HS3} sig_e;

  typedef struct {
    string nm;
    int    cyc;
    sig_e  sig;
    int    exp;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] sample(input sig_e s);
    case (s)
      S_BLANK:  return {31'd0, bl};
      S_HS:     return {31'd0, hs};
      S_PX:     return {21'd0, px};
      S_PY:     return {21'd0, py};
      S_BLANK3: return {31'd0, bl3};
      default:  return {31'd0, hs3};
    endcase
  endfunction

  task automatic add(input string nm, input int cyc, input sig_e sig, input int exp);
    vec_t v;
    v.nm = nm; v.cyc = cyc; v.sig = sig; v.exp = exp;
    vecs.push_back(v);
  endtask

  task automatic randomize_colour();
    m_r = 8'($urandom);
    m_g = 8'($urandom);
    m_b = 8'($urandom);
  endtask

  // which: 0 = default instance, 2 = shrunken instance
  task automatic wait_xy(input int which, input int x, input int y, input int budget,
                         output bit ok);
    int i = 0;
    ok = 1'b0;
    while (!ok && i < budget) begin
      if (which == 0 ? (px == 11'(x) && py == 11'(y)) : (px_s == 11'(x) && py_s == 11'(y)))
        ok = 1'b1;
      else begin
        @(negedge CLK);
        i++;
      end
    end
  endtask

  // Coordinate seen at cycle t, colour driven at t+1, pixel checked at t+2.
  task automatic colour_probe(input string nm, input int which, input int x, input int y,
                              input bit show);
    bit ok;
    wait_xy(which, x, y, 3000, ok);
    check({nm, "_reach"}, {31'd0, ok}, 32'd1);
    if (ok) begin
      randomize_colour();
      @(negedge CLK);
      m_r = 8'hE0; m_g = 8'h1C; m_b = 8'hC0;
      @(negedge CLK);
      check(nm, which == 0 ? {8'd0, vr, vg, vb} : {8'd0, vr_s, vg_s, vb_s},
            show ? 32'h00E01CC0 : 32'h0);
      check({nm, "_blank"}, {31'd0, which == 0 ? bl : bl_s}, {31'd0, show});
      randomize_colour();
    end
  endtask

  initial begin
    bit ok;
    int sof_t[$];
    int vs_fall, vs_rise, hs_low;
    logic vs_prev;

    // Horizontal timing after release; pixelX == cycle for the first line.
    add("blank_c1", 1, S_BLANK, 0);    add("blank_c2", 2, S_BLANK, 1);
    add("blank_c641", 641, S_BLANK, 1); add("blank_c642", 642, S_BLANK, 0);
    add("hs_c657", 657, S_HS, 1);      add("hs_c658", 658, S_HS, 0);
    add("hs_c753", 753, S_HS, 0);      add("hs_c754", 754, S_HS, 1);
    add("px_c799", 799, S_PX, 799);    add("py_c799", 799, S_PY, 0);
    add("px_c800", 800, S_PX, 0);      add("py_c800", 800, S_PY, 1);
    add("p3_blank_c3", 3, S_BLANK3, 0); add("p3_blank_c4", 4, S_BLANK3, 1);
    add("p3_blank_c644", 644, S_BLANK3, 0);
    add("p3_hs_c659", 659, S_HS3, 1);  add("p3_hs_c660", 660, S_HS3, 0);
    add("p3_hs_c756", 756, S_HS3, 1);

    RESETn = 1'b0;
    randomize_colour();
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      randomize_colour();
    end
    #1;
    check("rst_rgb", {8'd0, vr, vg, vb}, 32'h0);
    check("rst_hs", {31'd0, hs}, 32'd1);
    check("rst_vs", {31'd0, vs}, 32'd1);
    check("rst_blank", {31'd0, bl}, 32'd0);
    check("rst_px", {21'd0, px}, 32'd0);
    check("rst_py", {21'd0, py}, 32'd0);
    check("rst_sof", {31'd0, sof}, 32'd1);
    check("sync_n", {31'd0, sn}, 32'd0);
    check("p3_rst_blank", {31'd0, bl3}, 32'd0);

    @(negedge CLK);
    RESETn = 1'b1;
    for (int c = 0; c <= 800; c++) begin
      foreach (vecs[k])
        if (vecs[k].cyc == c) check(vecs[k].nm, sample(vecs[k].sig), 32'(vecs[k].exp));
      if (c == 1) check("sof_drop", {31'd0, sof}, 32'd0);
      randomize_colour();
      @(negedge CLK);
    end

    colour_probe("rgb_x10", 0, 10, 1, 1'b1);
    colour_probe("rgb_x700", 0, 700, 1, 1'b0);

    // Mid-frame reset with a visible colour on the pins beforehand.
    wait_xy(0, 300, 2, 3000, ok);
    check("mid_reach", {31'd0, ok}, 32'd1);
    m_r = 8'hAA; m_g = 8'h55; m_b = 8'h33;
    @(negedge CLK);
    @(negedge CLK);
    check("mid_pre_rgb", {8'd0, vr, vg, vb}, 32'h00AA5533);
    RESETn = 1'b0;
    #1;
    check("mid_rgb", {8'd0, vr, vg, vb}, 32'h0);
    check("mid_blank", {31'd0, bl}, 32'd0);
    check("mid_px", {21'd0, px}, 32'd0);
    check("mid_py", {21'd0, py}, 32'd0);
    check("mid_sof", {31'd0, sof}, 32'd1);
    for (int i = 0; i < 3; i++) @(negedge CLK);
    check("mid_hold_px", {21'd0, px}, 32'd0);
    check("mid_hold_blank", {31'd0, bl}, 32'd0);
    RESETn = 1'b1;

    // Two-plus frames of the shrunken raster, plus restart checks on the default one.
    vs_fall = -1; vs_rise = -1; hs_low = 0; vs_prev = 1'b1;
    for (int n = 0; n < 420; n++) begin
      if (n == 1) begin
        check("restart_px", {21'd0, px}, 32'd1);
        check("restart_py", {21'd0, py}, 32'd0);
        check("restart_blank1", {31'd0, bl}, 32'd0);
      end
      if (n == 2) check("restart_blank2", {31'd0, bl}, 32'd1);
      if (sof_s) sof_t.push_back(n);
      if (vs_prev && !vs_s && vs_fall < 0) vs_fall = n;
      if (!vs_prev && vs_s && vs_rise < 0 && vs_fall >= 0) vs_rise = n;
      vs_prev = vs_s;
      if (n < 192 && !hs_s) hs_low++;
      @(negedge CLK);
    end
    check("sof_count", 32'(sof_t.size()), 32'd3);
    if (sof_t.size() >= 3) begin
      check("sof_period1", 32'(sof_t[1] - sof_t[0]), 32'd192);
      check("sof_period2", 32'(sof_t[2] - sof_t[1]), 32'd192);
    end
    check("vs_fall_cycle", 32'(vs_fall), 32'd130);
    check("vs_low_len", 32'(vs_rise - vs_fall), 32'd32);
    check("hs_low_frame", 32'(hs_low), 32'd36);

    colour_probe("s_rgb_vblank", 2, 2, 6, 1'b0);
    colour_probe("s_rgb_line0", 2, 2, 0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
